// File: rtl/dll_pkg.sv
// Shared DLL constants and the discriminator FSM state encoding.
package dll_pkg;

   localparam int unsigned DLL_MAG_WIDTH      = 11;
   localparam int unsigned DLL_DISC_FRAC_BITS = 10;

   typedef enum logic [1:0] {
      DISC_IDLE   = 2'd0,
      DISC_LOAD   = 2'd1,
      DISC_DIVIDE = 2'd2,
      DISC_DONE   = 2'd3
   } disc_state_e;

endpackage

// File: rtl/dll_serial_div.sv
// Unsigned restoring divider: one quotient bit per step, MSB first.
module dll_serial_div #(
   parameter int unsigned DIVISOR_W = 12,
   parameter int unsigned REM_W     = 13,
   parameter int unsigned QUOT_W    = 11
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load_i,
   input  logic                 step_i,
   input  logic [REM_W-1:0]     dividend_i,
   input  logic [DIVISOR_W-1:0] divisor_i,
   output logic [QUOT_W-1:0]    quot_o,
   output logic                 last_o
);

   localparam int unsigned CNT_W = $clog2(QUOT_W + 1);

   logic [REM_W-1:0]     rem_q, rem_d, rem_sub, div_ext;
   logic [DIVISOR_W-1:0] div_q;
   logic [QUOT_W-1:0]    quot_q, quot_d;
   logic [CNT_W-1:0]     cnt_q;
   logic                 ge;

   always_comb begin
      div_ext = {{(REM_W-DIVISOR_W){1'b0}}, div_q};
      ge      = (rem_q >= div_ext);
      rem_sub = ge ? (rem_q - div_ext) : rem_q;
      // Remainder stays below twice the divisor, so the bit shifted out is always zero.
      rem_d   = rem_sub << 1;
      quot_d  = {quot_q[QUOT_W-2:0], ge};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rem_q  <= '0;
         div_q  <= '0;
         quot_q <= '0;
         cnt_q  <= '0;
      end else if (load_i) begin
         rem_q  <= dividend_i;
         div_q  <= divisor_i;
         quot_q <= '0;
         cnt_q  <= CNT_W'(QUOT_W);
      end else if (step_i && (cnt_q != '0)) begin
         rem_q  <= rem_d;
         quot_q <= quot_d;
         cnt_q  <= cnt_q - CNT_W'(1);
      end
   end

   assign quot_o = quot_q;
   assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/dll_discriminator.sv
// Normalized early-minus-late discriminator (E-L)/(E+L) via a serial divider.
// Optional: `define DLL_DISC_CLAMP_EN clamps |result| to 1 - 2^-FRAC_BITS.
module dll_discriminator
   import dll_pkg::*;
#(
   parameter int unsigned MAG_WIDTH = DLL_MAG_WIDTH,
   parameter int unsigned FRAC_BITS = DLL_DISC_FRAC_BITS,
   parameter int unsigned OUT_WIDTH = FRAC_BITS + 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [MAG_WIDTH-1:0] early_mag,
   input  logic [MAG_WIDTH-1:0] late_mag,
   output logic                 busy,
   output logic                 disc_valid,
   output logic [OUT_WIDTH-1:0] disc_out
);

   localparam int unsigned SUM_W = MAG_WIDTH + 1;
   localparam int unsigned REM_W = MAG_WIDTH + 2;
   localparam int unsigned Q_W   = FRAC_BITS + 1;

   disc_state_e          state_q;
   logic [MAG_WIDTH-1:0] early_q, late_q;
   logic                 neg_q, busy_q, valid_q;
   logic [OUT_WIDTH-1:0] disc_q, disc_d, mag_ext;
   logic [SUM_W-1:0]     sum_w, absdiff_w;
   logic [Q_W-1:0]       quot_w, mag_w;
   logic                 div_load, div_step, div_last;

   always_comb begin
      sum_w     = {1'b0, early_q} + {1'b0, late_q};
      absdiff_w = (late_q > early_q) ? ({1'b0, late_q} - {1'b0, early_q})
                                     : ({1'b0, early_q} - {1'b0, late_q});
      div_load  = (state_q == DISC_LOAD);
      div_step  = (state_q == DISC_DIVIDE);
      mag_w     = quot_w;
`ifdef DLL_DISC_CLAMP_EN
      if (quot_w == {1'b1, {FRAC_BITS{1'b0}}})
         mag_w = {1'b0, {FRAC_BITS{1'b1}}};
`endif
      mag_ext = {{(OUT_WIDTH-Q_W){1'b0}}, mag_w};
      disc_d  = neg_q ? -mag_ext : mag_ext;
   end

   dll_serial_div #(
      .DIVISOR_W (SUM_W),
      .REM_W     (REM_W),
      .QUOT_W    (Q_W)
   ) u_div (
      .clk        (clk),
      .reset      (reset),
      .load_i     (div_load),
      .step_i     (div_step),
      .dividend_i ({1'b0, absdiff_w}),
      .divisor_i  (sum_w),
      .quot_o     (quot_w),
      .last_o     (div_last)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= DISC_IDLE;
         early_q <= '0;
         late_q  <= '0;
         neg_q   <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         disc_q  <= '0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            DISC_IDLE: begin
               if (start) begin
                  early_q <= early_mag;
                  late_q  <= late_mag;
                  busy_q  <= 1'b1;
                  state_q <= DISC_LOAD;
               end
            end
            DISC_LOAD: begin
               neg_q <= (late_q > early_q);
               // Zero sum skips the divider; the load just cleared the quotient.
               state_q <= (sum_w == '0) ? DISC_DONE : DISC_DIVIDE;
            end
            DISC_DIVIDE: begin
               if (div_last)
                  state_q <= DISC_DONE;
            end
            DISC_DONE: begin
               disc_q  <= disc_d;
               valid_q <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= DISC_IDLE;
            end
            default: state_q <= DISC_IDLE;
         endcase
      end
   end

   assign busy       = busy_q;
   assign disc_valid = valid_q;
   assign disc_out   = disc_q;

endmodule

// File: tb/tb_dll_discriminator.sv
// Directed self-checking bench for dll_discriminator.
module tb_dll_discriminator;

   localparam int LAT = 13;
`ifdef DLL_DISC_CLAMP_EN
   localparam int FULL = 1023;
`else
   localparam int FULL = 1024;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [10:0] early_mag = '0;
   logic [10:0] late_mag = '0;
   logic        busy, disc_valid;
   logic [11:0] disc_out;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dll_discriminator dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .early_mag  (early_mag),
      .late_mag   (late_mag),
      .busy       (busy),
      .disc_valid (disc_valid),
      .disc_out   (disc_out)
   );

   // Called at a sample point (#1 after posedge); returns at the sample after the accepting edge.
   task automatic issue_start(input int e, input int l);
      early_mag = 11'(e);
      late_mag  = 11'(l);
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_valid(output int lat, output int val, output bit busy_ok, output bit busy_low);
      lat = -1; val = 0; busy_ok = 1'b1; busy_low = 1'b0;
      for (int n = 0; n <= 40; n++) begin
         if (disc_valid === 1'b1) begin
            lat = n;
            val = $signed(disc_out);
            busy_low = (busy === 1'b0);
            break;
         end
         if (busy !== 1'b1) busy_ok = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b1;
      early_mag = 11'd600;
      late_mag  = 11'd200;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
      n_checks++; if (disc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", disc_valid); end
      n_checks++; if (disc_out !== 12'd0) begin n_fail++; $display("FAIL reset_out: got %0d expected 0", $signed(disc_out)); end
      reset = 1'b0;
      start = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_start_dropped: busy got %0b expected 0", busy); end
   endtask

   task automatic test_basic();
      int te[3] = '{600, 100, 200};
      int tl[3] = '{200, 200, 600};
      int tv[3] = '{512, -341, -512};
      int lat, val;
      bit bok, blow;
      for (int i = 0; i < 3; i++) begin
         issue_start(te[i], tl[i]);
         wait_valid(lat, val, bok, blow);
         n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL basic_lat[%0d]: got %0d expected %0d", i, lat, LAT); end
         n_checks++; if (val !== tv[i]) begin n_fail++; $display("FAIL basic_val[%0d]: got %0d expected %0d", i, val, tv[i]); end
         n_checks++; if (bok !== 1'b1) begin n_fail++; $display("FAIL basic_busy_high[%0d]: got %0b expected 1", i, bok); end
         n_checks++; if (blow !== 1'b1) begin n_fail++; $display("FAIL basic_busy_low_at_valid[%0d]: got %0b expected 1", i, blow); end
      end
   endtask

   task automatic test_full_scale();
      int te[2] = '{2047, 0};
      int tl[2] = '{0, 5};
      int tv[2] = '{FULL, -FULL};
      int lat, val;
      bit bok, blow;
      for (int i = 0; i < 2; i++) begin
         issue_start(te[i], tl[i]);
         wait_valid(lat, val, bok, blow);
         n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL full_lat[%0d]: got %0d expected %0d", i, lat, LAT); end
         n_checks++; if (val !== tv[i]) begin n_fail++; $display("FAIL full_val[%0d]: got %0d expected %0d", i, val, tv[i]); end
      end
   endtask

   task automatic test_zero_sum();
      int te[3] = '{0, 600, 777};
      int tl[3] = '{0, 200, 777};
      int tlat[3] = '{2, LAT, LAT};
      int tv[3] = '{0, 512, 0};
      int lat, val;
      bit bok, blow;
      for (int i = 0; i < 3; i++) begin
         issue_start(te[i], tl[i]);
         wait_valid(lat, val, bok, blow);
         n_checks++; if (lat !== tlat[i]) begin n_fail++; $display("FAIL zero_lat[%0d]: got %0d expected %0d", i, lat, tlat[i]); end
         n_checks++; if (val !== tv[i]) begin n_fail++; $display("FAIL zero_val[%0d]: got %0d expected %0d", i, val, tv[i]); end
      end
   endtask

   task automatic test_back_to_back();
      int nvalid = 0;
      int lat1 = -1, lat2 = -1, val1 = 0, val2 = 0;
      issue_start(600, 200);
      for (int n = 0; n <= 40; n++) begin
         if (disc_valid === 1'b1) begin
            nvalid++;
            if (nvalid == 1) begin lat1 = n; val1 = $signed(disc_out); end
            if (nvalid == 2) begin lat2 = n; val2 = $signed(disc_out); end
         end
         start = 1'b0;
         if (n == 0 || n == 4 || n == 11) begin
            start = 1'b1; early_mag = 11'd0; late_mag = 11'd5;
         end else if (n == 13) begin
            start = 1'b1; early_mag = 11'd100; late_mag = 11'd200;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      n_checks++; if (nvalid !== 2) begin n_fail++; $display("FAIL b2b_valid_count: got %0d expected 2", nvalid); end
      n_checks++; if (lat1 !== LAT) begin n_fail++; $display("FAIL b2b_lat1: got %0d expected %0d", lat1, LAT); end
      n_checks++; if (val1 !== 512) begin n_fail++; $display("FAIL b2b_val1: got %0d expected 512", val1); end
      n_checks++; if (lat2 !== 14 + LAT) begin n_fail++; $display("FAIL b2b_lat2: got %0d expected %0d", lat2, 14 + LAT); end
      n_checks++; if (val2 !== -341) begin n_fail++; $display("FAIL b2b_val2: got %0d expected -341", val2); end
   endtask

   task automatic test_reset_mid();
      int nvalid = 0;
      int lat, val;
      bit bok, blow;
      issue_start(600, 200);
      repeat (4) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %0b expected 0", busy); end
      n_checks++; if (disc_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %0b expected 0", disc_valid); end
      n_checks++; if (disc_out !== 12'd0) begin n_fail++; $display("FAIL mid_reset_out: got %0d expected 0", $signed(disc_out)); end
      for (int n = 0; n < 20; n++) begin
         if (disc_valid === 1'b1) nvalid++;
         @(posedge clk); #1;
      end
      n_checks++; if (nvalid !== 0) begin n_fail++; $display("FAIL mid_reset_no_valid: got %0d expected 0", nvalid); end
      issue_start(200, 600);
      wait_valid(lat, val, bok, blow);
      n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL mid_reset_restart_lat: got %0d expected %0d", lat, LAT); end
      n_checks++; if (val !== -512) begin n_fail++; $display("FAIL mid_reset_restart_val: got %0d expected -512", val); end
   endtask

   initial begin
      #1;
      test_reset();
      test_basic();
      test_full_scale();
      test_zero_sum();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
